// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: scheduler state enum, sample width and tap delay clamp shared by delay_tap_scheduler
package delay_sched_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} sched_state_t;
  localparam int SAMPLE_W = 16;
  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned depth);
    return d == 0 ? 1 : d > depth - 1 ? depth - 1 : d;
  endfunction
endpackage

// File: rtl/delay_tap_addr.sv
// delay_tap_addr: read address of one tap, frame write address minus clamped delay, wrapping mod DEPTH
module delay_tap_addr import delay_sched_pkg::*; #(
  parameter int DEPTH = 65536,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] delay_i,
  output logic [ADDR_W-1:0] rd_addr_o
);
  assign rd_addr_o = wr_addr_i - ADDR_W'(clamp_delay(32'(delay_i), DEPTH));
endmodule

// File: rtl/delay_tap_scheduler.sv
// delay_tap_scheduler: per-frame write + NUM_TAPS reads on one shared delay BRAM; DELAY_SCHED_OVRCNT_EN adds overrun_count
module delay_tap_scheduler import delay_sched_pkg::*; #(
  parameter int DEPTH = 65536,
  parameter int NUM_TAPS = 4,
  parameter int BRAM_LAT = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic                         sample_in_valid,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay_flat,
  output logic [NUM_TAPS*SAMPLE_W-1:0] tap_out_flat,
  output logic                         taps_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic                         bram_we,
  output logic [SAMPLE_W-1:0]          bram_din,
  input  logic [SAMPLE_W-1:0]          bram_dout
`ifdef DELAY_SCHED_OVRCNT_EN
  ,
  output logic [15:0]                  overrun_count
`endif
);
  sched_state_t state_q, state_d;
  logic [7:0] k_q, k_d, tap_sel;
  logic [ADDR_W-1:0] wr_ptr_q, rd_addr;
  logic [SAMPLE_W-1:0] sample_q;
  logic [NUM_TAPS*ADDR_W-1:0] delays_q;
  logic [BRAM_LAT-1:0] pv_q;
  logic [7:0] pk_q [BRAM_LAT];
  logic [NUM_TAPS*SAMPLE_W-1:0] stage_q, stage_d, taps_q;
  logic taps_valid_q, overrun_q, drop, last_cap;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    case (state_q)
      IDLE: state_d = sample_in_valid ? WRITE : IDLE;
      WRITE: begin
        state_d = READ;
        k_d = '0;
      end
      READ: begin
        state_d = k_q == 8'(NUM_TAPS - 1) ? DRAIN : READ;
        k_d = k_q == 8'(NUM_TAPS - 1) ? '0 : k_q + 8'd1;
      end
      default: begin
        state_d = k_q == 8'(BRAM_LAT - 1) ? IDLE : DRAIN;
        k_d = k_q + 8'd1;
      end
    endcase
  end
  assign tap_sel = state_q == READ ? k_q : '0;
  delay_tap_addr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr (
    .wr_addr_i(wr_ptr_q - ADDR_W'(1)),
    .delay_i  (delays_q[tap_sel*ADDR_W +: ADDR_W]),
    .rd_addr_o(rd_addr)
  );
  assign drop = sample_in_valid && state_q != IDLE;
  assign last_cap = pv_q[BRAM_LAT-1] && pk_q[BRAM_LAT-1] == 8'(NUM_TAPS - 1);
  always_comb begin
    stage_d = stage_q;
    if (pv_q[BRAM_LAT-1]) stage_d[pk_q[BRAM_LAT-1]*SAMPLE_W +: SAMPLE_W] = bram_dout;
  end
  assign busy = state_q != IDLE;
  assign bram_we = state_q == WRITE && !rst;
  assign bram_addr = state_q == WRITE ? wr_ptr_q : state_q == READ ? rd_addr : '0;
  assign bram_din = state_q == WRITE ? sample_q : '0;
  assign tap_out_flat = taps_q;
  assign taps_valid = taps_valid_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      wr_ptr_q <= '0;
      sample_q <= '0;
      delays_q <= '0;
      pv_q <= '0;
      stage_q <= '0;
      taps_q <= '0;
      taps_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      if (state_q == IDLE && sample_in_valid) begin
        sample_q <= sample_in;
        delays_q <= tap_delay_flat;
      end
      if (state_q == WRITE) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      pv_q[0] <= state_q == READ;
      for (int i = 1; i < BRAM_LAT; i++) pv_q[i] <= pv_q[i-1];
      stage_q <= stage_d;
      if (last_cap) taps_q <= stage_d;
      taps_valid_q <= last_cap;
      if (drop) overrun_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    pk_q[0] <= k_q;
    for (int i = 1; i < BRAM_LAT; i++) pk_q[i] <= pk_q[i-1];
  end
`ifdef DELAY_SCHED_OVRCNT_EN
  logic [15:0] ovr_cnt_q;
  always_ff @(posedge clk) ovr_cnt_q <= rst ? '0 : ovr_cnt_q + 16'(drop && ovr_cnt_q != '1);
  assign overrun_count = ovr_cnt_q;
`endif
endmodule

// File: tb/tb_delay_tap_scheduler.sv
// tb_delay_tap_scheduler: randomized frames on a 64K and a 4-deep scheduler checked against a sample-history model
module tb_delay_tap_scheduler;
  logic clk = 1'b0, rst = 1'b1, mem_clr = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] sample_in = '0;
  logic sample_in_valid = 1'b0;
  logic [63:0] tap_delay_flat = '0, tap_out_flat, tap_out4;
  logic [7:0] tap_delay4 = '0;
  logic taps_valid, busy, overrun, bram_we, taps_valid4, busy4, overrun4, bram_we4;
  logic [15:0] bram_addr, bram_din, bram_dout, bram_din4, bram_dout4;
  logic [1:0] bram_addr4;
`ifdef DELAY_SCHED_OVRCNT_EN
  logic [15:0] ovc, ovc4;
`endif
  delay_tap_scheduler u_dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .tap_delay_flat(tap_delay_flat), .tap_out_flat(tap_out_flat), .taps_valid(taps_valid),
    .busy(busy), .overrun(overrun), .bram_addr(bram_addr), .bram_we(bram_we),
    .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef DELAY_SCHED_OVRCNT_EN
    , .overrun_count(ovc)
`endif
  );
  delay_tap_scheduler #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
    .tap_delay_flat(tap_delay4), .tap_out_flat(tap_out4), .taps_valid(taps_valid4),
    .busy(busy4), .overrun(overrun4), .bram_addr(bram_addr4), .bram_we(bram_we4),
    .bram_din(bram_din4), .bram_dout(bram_dout4)
`ifdef DELAY_SCHED_OVRCNT_EN
    , .overrun_count(ovc4)
`endif
  );
  logic [15:0] mem [65536];
  logic [15:0] mem4 [4];
  logic [15:0] r1, r2, r14, r24;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 65536; i++) mem[i] <= '0;
    else if (bram_we) mem[bram_addr] <= bram_din;
    if (mem_clr) for (int i = 0; i < 4; i++) mem4[i] <= '0;
    else if (bram_we4) mem4[bram_addr4] <= bram_din4;
    r1 <= mem[bram_addr];
    r2 <= r1;
    r14 <= mem4[bram_addr4];
    r24 <= r14;
  end
  assign bram_dout = r2;
  assign bram_dout4 = r24;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] ref_mem [65536];
  logic [15:0] ref_mem4 [4];
  int ref_wp, ref_wp4;
  logic [15:0] exp_wr;
  logic [63:0] exp_rd, exp_taps, exp_taps4;
  logic [32:0] obs_wr;
  logic [63:0] obs_rd, obs_taps, obs_taps4;
  logic obs_rd_we;
  int obs_tv, obs_tv4;
  bit obs_busy_ok;
  task automatic model_frame(input logic [15:0] s, input logic [63:0] dl, input logic [7:0] dl4);
    int d, a;
    exp_wr = 16'(ref_wp);
    for (int k = 0; k < 4; k++) begin
      d = int'(dl[k*16 +: 16]);
      d = d == 0 ? 1 : d;
      a = (ref_wp + 65536 - d) % 65536;
      exp_rd[k*16 +: 16] = 16'(a);
      exp_taps[k*16 +: 16] = ref_mem[a];
      d = int'(dl4[k*2 +: 2]);
      d = d == 0 ? 1 : d;
      exp_taps4[k*16 +: 16] = ref_mem4[(ref_wp4 + 4 - d) % 4];
    end
    ref_mem[ref_wp] = s;
    ref_wp = (ref_wp + 1) % 65536;
    ref_mem4[ref_wp4] = s;
    ref_wp4 = (ref_wp4 + 1) % 4;
  endtask
  task automatic run_frame(input logic [15:0] s, input logic [63:0] dl, input logic [7:0] dl4,
                           input int extra_at, input int chg_at, input logic [63:0] chg_dl);
    sample_in = s;
    tap_delay_flat = dl;
    tap_delay4 = dl4;
    sample_in_valid = 1'b1;
    obs_tv = 0;
    obs_tv4 = 0;
    obs_busy_ok = 1'b1;
    obs_rd_we = 1'b0;
    obs_rd = 'x;
    obs_wr = 'x;
    obs_taps = 'x;
    obs_taps4 = 'x;
    for (int c = 1; c <= 20 && obs_tv == 0; c++) begin
      @(posedge clk);
      #1;
      sample_in_valid = c == extra_at;
      if (c == extra_at) sample_in = ~s;
      if (c == chg_at) tap_delay_flat = chg_dl;
      if (c == 1) obs_wr = {bram_we, bram_addr, bram_din};
      if (c >= 2 && c <= 5) begin
        obs_rd[(c-2)*16 +: 16] = bram_addr;
        obs_rd_we = obs_rd_we | bram_we;
      end
      if (taps_valid4 && obs_tv4 == 0) begin
        obs_tv4 = c;
        obs_taps4 = tap_out4;
      end
      if (busy !== !taps_valid) obs_busy_ok = 1'b0;
      if (taps_valid) begin
        obs_tv = c;
        obs_taps = tap_out_flat;
      end
    end
    sample_in_valid = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++) ref_mem4[i] = '0;
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({taps_valid, busy, overrun, bram_we, bram_addr, bram_din} !== '0) begin n_fail++; $display("FAIL reset_held_outputs: got %h want 0", {taps_valid, busy, overrun, bram_we, bram_addr, bram_din}); end
    rst = 1'b0;
    mem_clr = 1'b0;
    ref_wp = 0;
    ref_wp4 = 0;
    @(posedge clk);
    #1;
    n_cmp++; if ({taps_valid, busy, overrun, bram_we, bram_addr, bram_din, tap_out_flat} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {taps_valid, busy, overrun, bram_we, bram_addr, bram_din, tap_out_flat}); end
`ifdef DELAY_SCHED_OVRCNT_EN
    n_cmp++; if (ovc !== 16'd0) begin n_fail++; $display("FAIL reset_ovrcnt: got %0d want 0", ovc); end
`endif
  endtask
  task automatic test_first_frame();
    logic [63:0] dl = {16'd4, 16'd3, 16'd2, 16'd1};
    model_frame(16'h1234, dl, 8'b00_11_10_01);
    run_frame(16'h1234, dl, 8'b00_11_10_01, 0, 0, '0);
    n_cmp++; if (obs_wr !== {1'b1, 16'h0000, 16'h1234}) begin n_fail++; $display("FAIL first_write: got %h want %h", obs_wr, {1'b1, 16'h0000, 16'h1234}); end
    n_cmp++; if (obs_rd !== {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}) begin n_fail++; $display("FAIL first_reads: got %h want fffcfffdfffeffff", obs_rd); end
    n_cmp++; if (obs_rd_we !== 1'b0) begin n_fail++; $display("FAIL first_read_we: got %b want 0", obs_rd_we); end
    n_cmp++; if (obs_tv !== 8) begin n_fail++; $display("FAIL first_latency: got %0d want 8", obs_tv); end
    n_cmp++; if (obs_busy_ok !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b want 1", obs_busy_ok); end
    n_cmp++; if (obs_taps !== 64'd0) begin n_fail++; $display("FAIL first_taps: got %h want 0", obs_taps); end
  endtask
  task automatic test_history();
    logic [63:0] dl = {16'd0, 16'd5, 16'd3, 16'd1};
    for (int i = 1; i <= 10; i++) begin
      model_frame(16'(i), dl, 8'h1B);
      run_frame(16'(i), dl, 8'h1B, 0, 0, '0);
      n_cmp++; if (obs_taps !== exp_taps) begin n_fail++; $display("FAIL history_taps[%0d]: got %h want %h", i, obs_taps, exp_taps); end
    end
    model_frame(16'h00AA, dl, 8'h1B);
    run_frame(16'h00AA, dl, 8'h1B, 0, 0, '0);
    n_cmp++; if (obs_taps !== {16'd10, 16'd6, 16'd8, 16'd10}) begin n_fail++; $display("FAIL history_final: got %h want 000a00060008000a", obs_taps); end
  endtask
  task automatic test_random();
    logic [63:0] dl;
    logic [7:0] dl4;
    logic [15:0] s;
    for (int n = 0; n < 20; n++) begin
      s = 16'($urandom);
      dl4 = 8'($urandom);
      for (int k = 0; k < 4; k++)
        dl[k*16 +: 16] = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 40));
      model_frame(s, dl, dl4);
      run_frame(s, dl, dl4, 0, 0, '0);
      n_cmp++; if (obs_wr !== {1'b1, exp_wr, s}) begin n_fail++; $display("FAIL rand_write[%0d]: got %h want %h", n, obs_wr, {1'b1, exp_wr, s}); end
      n_cmp++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rand_reads[%0d]: got %h want %h", n, obs_rd, exp_rd); end
      n_cmp++; if ({obs_rd_we, obs_busy_ok} !== 2'b01) begin n_fail++; $display("FAIL rand_we_busy[%0d]: got %b want 01", n, {obs_rd_we, obs_busy_ok}); end
      n_cmp++; if (obs_tv !== 8 || obs_tv4 !== 8) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d/%0d want 8/8", n, obs_tv, obs_tv4); end
      n_cmp++; if (obs_taps !== exp_taps) begin n_fail++; $display("FAIL rand_taps[%0d]: got %h want %h", n, obs_taps, exp_taps); end
      n_cmp++; if (obs_taps4 !== exp_taps4) begin n_fail++; $display("FAIL rand_taps4[%0d]: got %h want %h", n, obs_taps4, exp_taps4); end
    end
  endtask
  task automatic test_overrun();
    logic [63:0] dl = {16'd2, 16'd1, 16'd1, 16'd1};
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_before: got %b want 0", overrun); end
    model_frame(16'h7E57, dl, 8'h55);
    run_frame(16'h7E57, dl, 8'h55, 3, 0, '0);
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    n_cmp++; if (obs_tv !== 8 || obs_taps !== exp_taps) begin n_fail++; $display("FAIL overrun_frame: got %0d %h want 8 %h", obs_tv, obs_taps, exp_taps); end
`ifdef DELAY_SCHED_OVRCNT_EN
    n_cmp++; if (ovc !== 16'd1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", ovc); end
`endif
    model_frame(16'h0BAD, dl, 8'h55);
    run_frame(16'h0BAD, dl, 8'h55, 0, 0, '0);
    n_cmp++; if (obs_wr !== {1'b1, exp_wr, 16'h0BAD}) begin n_fail++; $display("FAIL overrun_next_write: got %h want %h", obs_wr, {1'b1, exp_wr, 16'h0BAD}); end
    n_cmp++; if (obs_taps !== exp_taps) begin n_fail++; $display("FAIL overrun_next_taps: got %h want %h", obs_taps, exp_taps); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask
  task automatic test_delay_change();
    logic [63:0] da = {16'd4, 16'd3, 16'd2, 16'd1};
    logic [63:0] db = {16'd11, 16'd9, 16'd7, 16'd6};
    model_frame(16'h4444, da, 8'h39);
    run_frame(16'h4444, da, 8'h39, 0, 3, db);
    n_cmp++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL chg_latched_reads: got %h want %h", obs_rd, exp_rd); end
    n_cmp++; if (obs_taps !== exp_taps) begin n_fail++; $display("FAIL chg_latched_taps: got %h want %h", obs_taps, exp_taps); end
    model_frame(16'h5555, db, 8'h39);
    run_frame(16'h5555, db, 8'h39, 0, 0, '0);
    n_cmp++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL chg_next_reads: got %h want %h", obs_rd, exp_rd); end
    n_cmp++; if (obs_taps !== exp_taps) begin n_fail++; $display("FAIL chg_next_taps: got %h want %h", obs_taps, exp_taps); end
  endtask
  task automatic test_wrap();
    logic [15:0] s;
    for (int i = 0; i < 6; i++) begin
      s = 16'(16'hA0 + i);
      model_frame(s, {16'd3, 16'd2, 16'd1, 16'd0}, 8'hFF);
      run_frame(s, {16'd3, 16'd2, 16'd1, 16'd0}, 8'hFF, 0, 0, '0);
      n_cmp++; if (obs_taps4 !== exp_taps4 || obs_tv4 !== 8) begin n_fail++; $display("FAIL wrap_taps4[%0d]: got %h @%0d want %h @8", i, obs_taps4, obs_tv4, exp_taps4); end
      if (i >= 3) begin
        n_cmp++; if (obs_taps4 !== {4{16'(16'hA0 + i - 3)}}) begin n_fail++; $display("FAIL wrap_age[%0d]: got %h want 4x%h", i, obs_taps4, 16'(16'hA0 + i - 3)); end
      end
    end
  endtask
  task automatic test_rst_mid();
    bit tv_seen = 1'b0;
    logic [63:0] dl = {16'd3, 16'd2, 16'd1, 16'd4};
    sample_in = 16'h5A5A;
    sample_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_same_cycle: got %b want 0", bram_we); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_wp = 0;
    ref_wp4 = 0;
    n_cmp++; if ({busy, overrun} !== 2'b00) begin n_fail++; $display("FAIL rst_write_idle: got %b want 00", {busy, overrun}); end
    model_frame(16'h6B6B, dl, 8'h1B);
    sample_in = 16'h6B6B;
    tap_delay_flat = dl;
    tap_delay4 = 8'h1B;
    sample_in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      sample_in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_wp = 0;
    ref_wp4 = 0;
    n_cmp++; if ({busy, bram_we, bram_addr} !== '0) begin n_fail++; $display("FAIL rst_read_idle: got %h want 0", {busy, bram_we, bram_addr}); end
    repeat (12) begin
      @(posedge clk);
      #1;
      if (taps_valid || taps_valid4) tv_seen = 1'b1;
    end
    n_cmp++; if (tv_seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_taps_valid: got %b want 0", tv_seen); end
    model_frame(16'h7C7C, dl, 8'h1B);
    run_frame(16'h7C7C, dl, 8'h1B, 0, 0, '0);
    n_cmp++; if (obs_wr !== {1'b1, 16'h0000, 16'h7C7C}) begin n_fail++; $display("FAIL rst_next_write: got %h want 100007c7c", obs_wr); end
    n_cmp++; if (obs_taps !== exp_taps || obs_taps4 !== exp_taps4) begin n_fail++; $display("FAIL rst_next_taps: got %h/%h want %h/%h", obs_taps, obs_taps4, exp_taps, exp_taps4); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_first_frame();
    test_history();
    test_random();
    test_overrun();
    test_delay_change();
    test_wrap();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
